// File: rtl/data_mem_responder.sv
// Single-outstanding word memory responder: accepts one load/store, answers after
// LATENCY cycles, and holds the response until the initiator takes it.
module data_mem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic [DW-1:0]   mem [DEPTH];

    logic            use_inputs;
    logic            op_write;
    logic [AW-1:0]   op_addr;
    logic [DW-1:0]   op_wdata;
    logic            op_in_range;
    logic [DW-1:0]   rd_word;
    logic            enter_resp;
    logic            mem_we;

    // With LATENCY=1 the commit happens on the acceptance edge, before the latches hold the request
    always_comb begin
        use_inputs  = (state_q == IDLE);
        op_write    = use_inputs ? req_write : wr_q;
        op_addr     = use_inputs ? req_addr  : addr_q;
        op_wdata    = use_inputs ? req_wdata : wdata_q;
        op_in_range = ({1'b0, op_addr} < 17'(DEPTH));
        rd_word     = mem[op_addr[IW-1:0]];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        enter_resp   = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    enter_resp = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = !op_in_range;
            resp_rdata_d = (!op_write && op_in_range) ? rd_word : '0;
            mem_we       = op_write && op_in_range;
        end

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage is never reset; reset only blocks a pending commit
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[op_addr[IW-1:0]] <= op_wdata;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance a (LATENCY=2) and instance b (LATENCY=1) share stimulus,
// req_valid is steered to one of them by sel.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        rr_a, rv_a, er_a, rr_b, rv_b, er_b;
    logic [31:0] rd_a, rd_b;
    logic        cur_rr, cur_rv, cur_er;
    logic [31:0] cur_rd;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int acc_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_a (
        .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rr_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_a), .resp_ready(resp_ready), .resp_rdata(rd_a), .resp_err(er_a)
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_b (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rr_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_b), .resp_ready(resp_ready), .resp_rdata(rd_b), .resp_err(er_b)
    );

    assign cur_rr = sel ? rr_b : rr_a;
    assign cur_rv = sel ? rv_b : rv_a;
    assign cur_er = sel ? er_b : er_a;
    assign cur_rd = sel ? rd_b : rd_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for req_ready, return just after the accepting edge
    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        for (int k = 0; k < 20 && !cur_rr; k++) tick();
        check("accept_ready", 32'(cur_rr), 32'd1);
        tick();
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    // Cycle number (1 = first sample after acceptance) at which resp_valid is seen; 0 on timeout
    task automatic wait_resp(output int lat);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (cur_rv) begin
                lat = k;
                break;
            end
            tick();
        end
    endtask

    task automatic xact(input string tag, input logic w, input logic [15:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_er);
        int lat;
        issue(w, a, d);
        wait_resp(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, cur_rd, exp_rd);
        check({tag, "_err"}, 32'(cur_er), 32'(exp_er));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        int prev;
        rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

        tick(); tick();
        check("rst_req_ready", 32'(rr_a), 32'd0);
        check("rst_resp_valid", 32'(rv_a), 32'd0);
        check("rst_rdata", rd_a, 32'd0);
        check("rst_err", 32'(er_a), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(rr_a), 32'd1);

        xact("st5", 1'b1, 16'd5, 32'hDEADBEEF, 2, 32'd0, 1'b0);
        xact("ld5", 1'b0, 16'd5, 32'h0, 2, 32'hDEADBEEF, 1'b0);
        xact("st0", 1'b1, 16'd0, 32'hA5A50000, 2, 32'd0, 1'b0);
        xact("ld256", 1'b0, 16'd256, 32'h0, 2, 32'd0, 1'b1);
        xact("ld0", 1'b0, 16'd0, 32'h0, 2, 32'hA5A50000, 1'b0);
        xact("st261", 1'b1, 16'd261, 32'h11111111, 2, 32'd0, 1'b1);
        xact("ld5_alias", 1'b0, 16'd5, 32'h0, 2, 32'hDEADBEEF, 1'b0);
        xact("ldffff", 1'b0, 16'hFFFF, 32'h0, 2, 32'd0, 1'b1);
        xact("st255", 1'b1, 16'd255, 32'h00FF00FF, 2, 32'd0, 1'b0);
        xact("ld255", 1'b0, 16'd255, 32'h0, 2, 32'h00FF00FF, 1'b0);

        // Response held while resp_ready stays low
        resp_ready = 1'b0;
        issue(1'b0, 16'd5, 32'h0);
        wait_resp(lat);
        check("hold_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(cur_rv), 32'd1);
            check("hold_rdata", cur_rd, 32'hDEADBEEF);
            check("hold_err", 32'(cur_er), 32'd0);
            check("hold_req_ready", 32'(cur_rr), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check("release_valid", 32'(cur_rv), 32'd0);
        check("release_req_ready", 32'(cur_rr), 32'd1);

        // Reset while a store waits: no commit
        xact("st9", 1'b1, 16'd9, 32'hCAFE0009, 2, 32'd0, 1'b0);
        issue(1'b1, 16'd9, 32'h12345678);
        rst = 1'b1;
        tick();
        check("wrst_valid", 32'(cur_rv), 32'd0);
        check("wrst_rdata", cur_rd, 32'd0);
        check("wrst_err", 32'(cur_er), 32'd0);
        check("wrst_req_ready", 32'(cur_rr), 32'd0);
        rst = 1'b0;
        tick();
        check("wrst_ready_after", 32'(cur_rr), 32'd1);
        xact("ld9", 1'b0, 16'd9, 32'h0, 2, 32'hCAFE0009, 1'b0);

        // Reset while a response is held discards it
        resp_ready = 1'b0;
        issue(1'b0, 16'd9, 32'h0);
        wait_resp(lat);
        check("rrst_lat", 32'(lat), 32'd2);
        rst = 1'b1;
        tick();
        check("rrst_valid", 32'(cur_rv), 32'd0);
        check("rrst_rdata", cur_rd, 32'd0);
        rst = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("rrst_ready_after", 32'(cur_rr), 32'd1);

        // Address changes after acceptance are ignored; held req_valid waits for IDLE
        issue(1'b0, 16'd5, 32'h0);
        prev = acc_cyc;
        req_valid = 1'b1;
        req_addr  = 16'd0;
        check("latch_req_ready_wait", 32'(cur_rr), 32'd0);
        wait_resp(lat);
        check("latch_lat", 32'(lat), 32'd2);
        check("latch_rdata", cur_rd, 32'hDEADBEEF);
        tick();
        xact("latch_next", 1'b0, 16'd0, 32'h0, 2, 32'hA5A50000, 1'b0);
        check("latch_spacing", 32'(acc_cyc - prev), 32'd3);

        // LATENCY=1 instance, back-to-back stores then loads
        sel = 1'b1;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 16'(i + 1), 32'h10000000 + 32'(i));
            check("b_st_valid", 32'(cur_rv), 32'd1);
            check("b_st_rdata", cur_rd, 32'd0);
            check("b_st_err", 32'(cur_er), 32'd0);
            if (i > 0) check("b_st_spacing", 32'(acc_cyc - prev), 32'd2);
            prev = acc_cyc;
            tick();
            check("b_st_drop", 32'(cur_rv), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 16'(i + 1), 32'h0);
            check("b_ld_valid", 32'(cur_rv), 32'd1);
            check("b_ld_rdata", cur_rd, 32'h10000000 + 32'(i));
            check("b_ld_spacing", 32'(acc_cyc - prev), 32'd2);
            prev = acc_cyc;
            tick();
        end
        check("a_idle_untouched", 32'(rv_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
